// File: rtl/vga_plot_pkg.sv
// Shared types and screen geometry for the VGA plot consumer.
package vga_plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOR_W  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // One buffered plot request; 30 bits packed as {x, y, color}.
  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } plot_req_t;

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO with show-ahead output. Pushes while full and pops
// while empty are ignored, so callers may gate loosely.
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_plotter.sv
// Accepts plot requests, buffers them, and replays them one pixel per cycle
// onto the VGA adapter write port; also sweeps the whole screen on a clear.
//
// Handshake: a request transfers at every rising edge where req_valid and
// req_ready are both high; req_valid and payload are held stable by the
// producer, and req_ready depends only on registered state.
module vga_plotter
  import vga_plot_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = vga_plot_pkg::SCREEN_W,
  parameter int SCREEN_H   = vga_plot_pkg::SCREEN_H
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x,
  input  logic [6:0]  req_y,
  input  logic [14:0] req_color,
  input  logic        clear_start,
  input  logic [14:0] clear_color,
  output logic        busy,
  output logic        oob,
  output logic [7:0]  out_x,
  output logic [6:0]  out_y,
  output logic [14:0] out_colour,
  output logic        out_plot,
  output logic [1:0]  dbg_state
);

  state_t      state, state_next;
  logic        clear_pend, pend_next;
  logic [14:0] clr_color, ccol_next;
  logic [7:0]  sx, sx_next;
  logic [6:0]  sy, sy_next;
  logic        plot_next;
  logic [7:0]  x_next;
  logic [6:0]  y_next;
  logic [14:0] col_next;

  plot_req_t   fifo_din, fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        accept, in_range, push, pop;
  logic        enter_clear, sweeping, last_px;
  logic [7:0]  px;
  logic [6:0]  py;

  assign req_ready   = !fifo_full && !clear_pend && (state != CLEAR);
  assign accept      = req_valid && req_ready;
  assign in_range    = (32'(req_x) < SCREEN_W) && (32'(req_y) < SCREEN_H);
  assign push        = accept && in_range;
  assign pop         = (state != CLEAR) && !fifo_empty;
  // The sweep starts only once every request queued ahead of it has drained.
  assign enter_clear = (state != CLEAR) && clear_pend && fifo_empty;
  assign sweeping    = (state == CLEAR) || enter_clear;
  assign px          = enter_clear ? '0 : sx;
  assign py          = enter_clear ? '0 : sy;
  assign last_px     = (px == 8'(SCREEN_W - 1)) && (py == 7'(SCREEN_H - 1));
  assign busy        = !fifo_empty || clear_pend || (state == CLEAR);
  assign dbg_state   = state;

  assign fifo_din = '{x: req_x, y: req_y, color: req_color};

  plot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(plot_req_t))
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state, clear bookkeeping, sweep counters and next output pixel.
  always_comb begin
    state_next = state;
    pend_next  = clear_pend;
    ccol_next  = clr_color;
    sx_next    = sx;
    sy_next    = sy;
    plot_next  = 1'b0;
    x_next     = out_x;
    y_next     = out_y;
    col_next   = out_colour;

    if (clear_start && !clear_pend && (state != CLEAR)) begin
      pend_next = 1'b1;
      ccol_next = clear_color;
    end

    if (pop) begin
      plot_next  = 1'b1;
      x_next     = fifo_dout.x;
      y_next     = fifo_dout.y;
      col_next   = fifo_dout.color;
      state_next = DRAIN;
    end else if (sweeping) begin
      plot_next = 1'b1;
      x_next    = px;
      y_next    = py;
      col_next  = clr_color;
      if (last_px) begin
        state_next = IDLE;
        pend_next  = 1'b0;
        sx_next    = '0;
        sy_next    = '0;
      end else begin
        state_next = CLEAR;
        if (px == 8'(SCREEN_W - 1)) begin
          sx_next = '0;
          sy_next = py + 7'd1;
        end else begin
          sx_next = px + 8'd1;
          sy_next = py;
        end
      end
    end else begin
      state_next = IDLE;
    end
  end

  // Datapath registers: adapter outputs, sweep position, clear latch, oob flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clear_pend <= 1'b0;
      clr_color  <= '0;
      sx         <= '0;
      sy         <= '0;
      out_plot   <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
      oob        <= 1'b0;
    end else begin
      clear_pend <= pend_next;
      clr_color  <= ccol_next;
      sx         <= sx_next;
      sy         <= sy_next;
      out_plot   <= plot_next;
      out_x      <= x_next;
      out_y      <= y_next;
      out_colour <= col_next;
      if (accept && !in_range) oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_plotter.sv
// Self-checking bench for vga_plotter: scenario tasks with a plot scoreboard.
module tb_vga_plotter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x;
  logic [6:0]  req_y;
  logic [14:0] req_color;
  logic        clear_start;
  logic [14:0] clear_color;
  logic        busy;
  logic        oob;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [14:0] out_colour;
  logic        out_plot;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes;
  logic [29:0] exp_q[$];
  logic [29:0] got;
  logic [29:0] exp_v;

  vga_plotter #(.FIFO_DEPTH(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .busy        (busy),
    .oob         (oob),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_colour  (out_colour),
    .out_plot    (out_plot),
    .dbg_state   (dbg_state)
  );

  // Clock and reset block.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_color = '0;
    clear_start = 1'b0; clear_color = '0;
    repeat (3) tick();
    n_checks++;
    if ({out_plot, busy, oob} !== 3'b000)
      $display("FAIL reset_flags: plot/busy/oob=%b required 000", {out_plot, busy, oob});
    n_checks++;
    if ({out_x, out_y, out_colour} !== 30'd0)
      $display("FAIL reset_pixel: got %h required 0", {out_x, out_y, out_colour});
    if ({out_plot, busy, oob} !== 3'b000 || {out_x, out_y, out_colour} !== 30'd0) n_fail++;
    resetn = 1'b1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_x = 8'd10; req_y = 7'd20; req_color = 15'h7FFF;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: req_ready=%b required 1", req_ready);
    end
    exp_q.push_back({8'd10, 7'd20, 15'h7FFF});
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (out_plot !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: plot=%b busy=%b required 0 1", out_plot, busy);
    end
    tick();
    n_checks++;
    got = {out_x, out_y, out_colour};
    if (out_plot !== 1'b1 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL single_plot: plot=%b required 1", out_plot);
    end else begin
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        n_fail++; $display("FAIL single_pixel: got %h required %h", got, exp_v);
      end
    end
    tick();
    n_checks++;
    if (out_plot !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: plot=%b busy=%b required 0 0", out_plot, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b0;
      if (i < 6) begin
        req_valid = 1'b1;
        req_x     = 8'($urandom_range(0, 159));
        req_y     = 7'($urandom_range(0, 119));
        req_color = 15'($urandom_range(0, 32767));
        n_checks++;
        if (req_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready: cycle %0d req_ready=%b required 1", i, req_ready);
        end
        exp_q.push_back({req_x, req_y, req_color});
      end
      tick();
      n_checks++;
      if (out_plot !== (i >= 1 && i <= 6)) begin
        n_fail++; $display("FAIL b2b_strobe: cycle %0d plot=%b required %b", i, out_plot, (i >= 1 && i <= 6));
      end
      if (out_plot) begin
        strobes++;
        got = {out_x, out_y, out_colour};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got %h required no strobe", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_fail++; $display("FAIL b2b_pixel: got %h required %h", got, exp_v);
          end
        end
      end
    end
    n_checks++;
    if (strobes != 6 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: strobes=%0d left=%0d required 6 0", strobes, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_oob();
    req_valid = 1'b1; req_x = 8'd160; req_y = 7'd0; req_color = 15'h1234;
    tick();
    n_checks++;
    if (out_plot !== 1'b0 || oob !== 1'b1) begin
      n_fail++; $display("FAIL oob_x: plot=%b oob=%b required 0 1", out_plot, oob);
    end
    req_x = 8'd0; req_y = 7'd120;
    tick();
    n_checks++;
    if (out_plot !== 1'b0) begin
      n_fail++; $display("FAIL oob_y: plot=%b required 0", out_plot);
    end
    req_x = 8'd159; req_y = 7'd119; req_color = 15'h2AAA;
    exp_q.push_back({8'd159, 7'd119, 15'h2AAA});
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (out_plot !== 1'b0) begin
      n_fail++; $display("FAIL oob_second: plot=%b required 0", out_plot);
    end
    tick();
    n_checks++;
    got = {out_x, out_y, out_colour};
    exp_v = exp_q.pop_front();
    if (out_plot !== 1'b1 || got !== exp_v) begin
      n_fail++; $display("FAIL oob_corner: plot=%b got %h required 1 %h", out_plot, got, exp_v);
    end
    tick();
    n_checks++;
    if (out_plot !== 1'b0 || oob !== 1'b1) begin
      n_fail++; $display("FAIL oob_sticky: plot=%b oob=%b required 0 1", out_plot, oob);
    end
  endtask

  task automatic test_clear_sweep();
    int cyc;
    cyc = 0;
    strobes = 0;
    while (cyc < 19400) begin
      req_valid = 1'b0; clear_start = 1'b0;
      if (cyc < 4) begin
        req_valid = 1'b1;
        req_x     = 8'(cyc * 30 + 3);
        req_y     = 7'(cyc * 25 + 1);
        req_color = 15'(16'h0100 + cyc);
        exp_q.push_back({req_x, req_y, req_color});
      end
      if (cyc == 3) begin
        clear_start = 1'b1; clear_color = 15'h001F;
        n_checks++;
        if (req_ready !== 1'b1) begin
          n_fail++; $display("FAIL clear_fourth_ready: req_ready=%b required 1", req_ready);
        end
        for (int k = 0; k < 19200; k++) exp_q.push_back({8'(k % 160), 7'(k / 160), 15'h001F});
      end
      if (strobes == 1000) begin
        clear_start = 1'b1; clear_color = 15'h7C00;
      end
      if (strobes == 2000) begin
        req_valid = 1'b1; req_x = 8'd1; req_y = 7'd1; req_color = 15'h3333;
      end
      tick();
      cyc++;
      if (out_plot) begin
        strobes++;
        got = {out_x, out_y, out_colour};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL clear_extra: got %h required no strobe", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_fail++; $display("FAIL clear_pixel: strobe %0d got %h required %h", strobes, got, exp_v);
          end
        end
      end
      if (strobes >= 3 && exp_q.size() != 0) begin
        n_checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL clear_ready: strobe %0d ready=%b busy=%b required 0 1", strobes, req_ready, busy);
        end
      end
      if (cyc > 4 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (exp_q.size() != 0 || strobes != 19204) begin
      n_fail++; $display("FAIL clear_count: strobes=%0d left=%0d required 19204 0", strobes, exp_q.size());
    end
    exp_q.delete();
    repeat (5) begin
      tick();
      n_checks++;
      if (out_plot !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL clear_after: plot=%b busy=%b required 0 0", out_plot, busy);
      end
    end
    n_checks++;
    if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL clear_idle: ready=%b state=%0d required 1 0", req_ready, dbg_state);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    cyc = 0;
    strobes = 0;
    n_checks++;
    if (oob !== 1'b1) begin
      n_fail++; $display("FAIL oob_hold: oob=%b required 1", oob);
    end
    while (strobes < 5000 && cyc < 6000) begin
      clear_start = 1'b0;
      if (cyc == 0) begin
        clear_start = 1'b1; clear_color = 15'h0ABC;
        for (int k = 0; k < 19200; k++) exp_q.push_back({8'(k % 160), 7'(k / 160), 15'h0ABC});
      end
      tick();
      cyc++;
      if (out_plot) begin
        strobes++;
        got = {out_x, out_y, out_colour};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (got !== exp_v) begin
          n_fail++; $display("FAIL sweep2_pixel: strobe %0d got %h required %h", strobes, got, exp_v);
        end
      end
    end
    clear_start = 1'b0;
    n_checks++;
    if (strobes != 5000) begin
      n_fail++; $display("FAIL sweep2_reach: strobes=%0d required 5000", strobes);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({out_plot, busy, oob} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_flags: plot/busy/oob=%b required 000", {out_plot, busy, oob});
    end
    exp_q.delete();
    repeat (2) tick();
    resetn = 1'b1;
    repeat (20) begin
      tick();
      n_checks++;
      if (out_plot !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midreset_quiet: plot=%b busy=%b required 0 0", out_plot, busy);
      end
    end
    req_valid = 1'b1; req_x = 8'd7; req_y = 7'd8; req_color = 15'h1111;
    exp_q.push_back({8'd7, 7'd8, 15'h1111});
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++;
    got = {out_x, out_y, out_colour};
    exp_v = exp_q.pop_front();
    if (out_plot !== 1'b1 || got !== exp_v) begin
      n_fail++; $display("FAIL midreset_new: plot=%b got %h required 1 %h", out_plot, got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_oob();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
